// File: rtl/accl_pkg.sv
// accl_pkg: shared tag type, FSM encoding and constants for the getAccl pair sequencer
package accl_pkg;
   localparam int ACCL_LATENCY = 122;
   localparam int ACCL_IDX_W = 4;
   localparam logic [63:0] FP64_ZERO = 64'h0;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} accl_seq_state_e;
   typedef struct packed {
      logic valid;
      logic [ACCL_IDX_W-1:0] idx;
      logic first;
      logic last;
   } accl_tag_t;
endpackage

// File: rtl/accl_tag_delay.sv
// accl_tag_delay: DEPTH-stage shift line of pair tags; ports clk, rst (sync active-low clear), din, dout (tail), any_valid (some stage holds a tag)
module accl_tag_delay
   import accl_pkg::*;
#(
   parameter int DEPTH = ACCL_LATENCY
) (
   input  logic      clk,
   input  logic      rst,
   input  accl_tag_t din,
   output accl_tag_t dout,
   output logic      any_valid
);
   accl_tag_t line [DEPTH];
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) line[k] <= '0;
      end else begin
         line[0] <= din;
         for (int k = 1; k < DEPTH; k++) line[k] <= line[k-1];
      end
   end
   always_comb begin
      any_valid = 1'b0;
      for (int k = 0; k < DEPTH; k++) any_valid = any_valid | line[k].valid;
   end
   assign dout = line[DEPTH-1];
endmodule

// File: rtl/accl_pair_sequencer.sv
// accl_pair_sequencer: issues every ordered body pair to getAccl and re-emits tagged ax/ay results
// ports: load_* write the body store, start/n_bodies begin a pass, busy/done report it,
// p_* feed getAccl, ax/ay come back LATENCY cycles later, res_* is the tagged result stream.
// ACCL_SEQ_ZERO_MASS_SKIP_EN: when defined, pairs whose source body has zero mass are not issued.
module accl_pair_sequencer
   import accl_pkg::*;
#(
   parameter int MAX_BODIES = 16,
   parameter int IDX_W      = $clog2(MAX_BODIES),
   parameter int LATENCY    = ACCL_LATENCY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_we,
   input  logic [IDX_W-1:0] load_idx,
   input  logic [63:0]      load_x,
   input  logic [63:0]      load_y,
   input  logic [63:0]      load_z,
   input  logic [63:0]      load_m,
   input  logic [IDX_W:0]   n_bodies,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [63:0]      p_x1,
   output logic [63:0]      p_y1,
   output logic [63:0]      p_z1,
   output logic [63:0]      p_x2,
   output logic [63:0]      p_y2,
   output logic [63:0]      p_m2,
   input  logic [63:0]      ax,
   input  logic [63:0]      ay,
   output logic             res_valid,
   output logic [IDX_W-1:0] res_idx,
   output logic             res_first,
   output logic             res_last,
   output logic [63:0]      res_ax,
   output logic [63:0]      res_ay
);
   accl_seq_state_e state, state_n;
   logic [63:0] sx [MAX_BODIES];
   logic [63:0] sy [MAX_BODIES];
   logic [63:0] sz [MAX_BODIES];
   logic [63:0] sm [MAX_BODIES];
   logic [IDX_W:0] n_reg, n_clamp, n_eff;
   logic [IDX_W-1:0] ci, cj, ni, nj;
   logic load_acc, start_acc, found, nlast, issue, fwd_i, fwd_j, line_busy;
   logic [MAX_BODIES-1:0] mask_eff;
   logic [63:0] x1_n, y1_n, z1_n, x2_n, y2_n, m2_n;
   accl_tag_t tag_n, p_tag, tail;

   assign load_acc  = load_we && state == S_IDLE;
   assign start_acc = start && state == S_IDLE;
   assign n_clamp   = n_bodies > (IDX_W+1)'(MAX_BODIES) ? (IDX_W+1)'(MAX_BODIES) : n_bodies;
   assign n_eff     = start_acc ? n_clamp : n_reg;
   assign issue     = (start_acc || state == S_ISSUE) && found;

`ifdef ACCL_SEQ_ZERO_MASS_SKIP_EN
   // A same-cycle load is folded in so a pass started alongside it sees the new mass.
   logic [MAX_BODIES-1:0] mask;
   always_ff @(posedge clk) begin
      if (!rst) mask <= '0;
      else if (load_acc) mask[load_idx] <= |load_m[62:0];
   end
   always_comb begin
      mask_eff = mask;
      if (load_acc) mask_eff[load_idx] = |load_m[62:0];
   end
`else
   assign mask_eff = '1;
`endif

   always_ff @(posedge clk) begin
      if (load_acc) begin
         sx[load_idx] <= load_x;
         sy[load_idx] <= load_y;
         sz[load_idx] <= load_z;
         sm[load_idx] <= load_m;
      end
   end

   // Next pair in (i, j) order after the current one, or the very first one on start.
   always_comb begin
      found = 1'b0;
      ni = '0;
      nj = '0;
      for (int a = 0; a < MAX_BODIES; a++)
         for (int b = 0; b < MAX_BODIES; b++)
            if (!found && a < int'(n_eff) && b < int'(n_eff) && a != b && mask_eff[b] &&
                (start_acc || a > int'(ci) || (a == int'(ci) && b > int'(cj)))) begin
               found = 1'b1;
               ni = IDX_W'(a);
               nj = IDX_W'(b);
            end
      nlast = 1'b1;
      for (int b = 0; b < MAX_BODIES; b++)
         if (b > int'(nj) && b < int'(n_eff) && b != int'(ni) && mask_eff[b]) nlast = 1'b0;
      tag_n = '0;
      tag_n.valid = issue;
      tag_n.idx = ACCL_IDX_W'(ni);
      tag_n.first = start_acc || ni != ci;
      tag_n.last = nlast;
   end

   // Store read with write-first forwarding for a load accepted together with start.
   always_comb begin
      fwd_i = load_acc && load_idx == ni;
      fwd_j = load_acc && load_idx == nj;
      x1_n = fwd_i ? load_x : sx[ni];
      y1_n = fwd_i ? load_y : sy[ni];
      z1_n = fwd_i ? load_z : sz[ni];
      x2_n = fwd_j ? load_x : sx[nj];
      y2_n = fwd_j ? load_y : sy[nj];
      m2_n = fwd_j ? load_m : sm[nj];
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  state_n = !start_acc ? S_IDLE : found ? S_ISSUE : S_DONE;
         S_ISSUE: state_n = found ? S_ISSUE : S_DRAIN;
         S_DRAIN: state_n = (p_tag.valid || line_busy) ? S_DRAIN : S_DONE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      busy = state == S_ISSUE || state == S_DRAIN;
      done = state == S_DONE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         n_reg <= '0;
         ci <= '0;
         cj <= '0;
         p_tag <= '0;
         p_x1 <= FP64_ZERO;
         p_y1 <= FP64_ZERO;
         p_z1 <= FP64_ZERO;
         p_x2 <= FP64_ZERO;
         p_y2 <= FP64_ZERO;
         p_m2 <= FP64_ZERO;
         res_valid <= 1'b0;
         res_idx <= '0;
         res_first <= 1'b0;
         res_last <= 1'b0;
         res_ax <= FP64_ZERO;
         res_ay <= FP64_ZERO;
      end else begin
         if (start_acc) n_reg <= n_clamp;
         p_tag <= tag_n;
         if (issue) begin
            ci <= ni;
            cj <= nj;
            p_x1 <= x1_n;
            p_y1 <= y1_n;
            p_z1 <= z1_n;
            p_x2 <= x2_n;
            p_y2 <= y2_n;
            p_m2 <= m2_n;
         end
         res_valid <= tail.valid;
         res_first <= tail.valid && tail.first;
         res_last <= tail.valid && tail.last;
         if (tail.valid) begin
            res_idx <= IDX_W'(tail.idx);
            res_ax <= ax;
            res_ay <= ay;
         end
      end
   end

   // p_tag is the tag of the pair currently on p_*, so the line adds exactly LATENCY cycles.
   accl_tag_delay #(.DEPTH(LATENCY)) u_tag_delay (
      .clk(clk),
      .rst(rst),
      .din(p_tag),
      .dout(tail),
      .any_valid(line_busy)
   );
endmodule

// File: tb/tb_accl_pair_sequencer.sv
// tb_accl_pair_sequencer: stub getAccl (echoes p_x2 as ax, p_m2 as ay) and a pair-list reference model
module tb_accl_pair_sequencer;
   localparam int LAT = 122;
   localparam int MB = 16;
`ifdef ACCL_SEQ_ZERO_MASS_SKIP_EN
   localparam bit SKIP = 1'b1;
   localparam int ZM_EXP = 4;
`else
   localparam bit SKIP = 1'b0;
   localparam int ZM_EXP = 6;
`endif
   logic clk, rst, load_we, start, busy, done, res_valid, res_first, res_last;
   logic [3:0] load_idx, res_idx;
   logic [4:0] n_bodies;
   logic [63:0] load_x, load_y, load_z, load_m, ax, ay, res_ax, res_ay;
   logic [63:0] p_x1, p_y1, p_z1, p_x2, p_y2, p_m2;
   logic [63:0] dx [LAT];
   logic [63:0] dm [LAT];
   logic [63:0] bx [MB];
   logic [63:0] by [MB];
   logic [63:0] bz [MB];
   logic [63:0] bm [MB];
   int passed = 0;
   int total = 0;

   typedef struct {int i; int j; bit first; bit last;} pr_t;
   typedef struct {int n; int restart; bit co_load; int exp_p; int exp_done;} vec_t;
   pr_t exp_q[$];
   vec_t tbl[7];

   accl_pair_sequencer dut (
      .clk(clk), .rst(rst), .load_we(load_we), .load_idx(load_idx),
      .load_x(load_x), .load_y(load_y), .load_z(load_z), .load_m(load_m),
      .n_bodies(n_bodies), .start(start), .busy(busy), .done(done),
      .p_x1(p_x1), .p_y1(p_y1), .p_z1(p_z1), .p_x2(p_x2), .p_y2(p_y2), .p_m2(p_m2),
      .ax(ax), .ay(ay), .res_valid(res_valid), .res_idx(res_idx),
      .res_first(res_first), .res_last(res_last), .res_ax(res_ax), .res_ay(res_ay)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      dx[0] <= p_x2;
      dm[0] <= p_m2;
      for (int k = 1; k < LAT; k++) begin
         dx[k] <= dx[k-1];
         dm[k] <= dm[k-1];
      end
   end
   assign ax = dx[LAT-1];
   assign ay = dm[LAT-1];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic bit zm(input logic [63:0] m);
      return m[62:0] == 63'd0;
   endfunction

   // Reference: every target i in order, every allowed source j in order.
   function automatic void build(input int n);
      int nn;
      int js[$];
      exp_q.delete();
      nn = n > MB ? MB : n;
      for (int i = 0; i < nn; i++) begin
         js.delete();
         for (int j = 0; j < nn; j++)
            if (j != i && !(SKIP && zm(bm[j]))) js.push_back(j);
         for (int k = 0; k < js.size(); k++)
            exp_q.push_back('{i: i, j: js[k], first: (k == 0), last: (k == js.size() - 1)});
      end
   endfunction

   function automatic logic [383:0] pvec();
      return {p_x1, p_y1, p_z1, p_x2, p_y2, p_m2};
   endfunction

   function automatic logic any_out();
      return |{busy, done, p_x1, p_y1, p_z1, p_x2, p_y2, p_m2,
               res_valid, res_idx, res_first, res_last, res_ax, res_ay};
   endfunction

   task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic rand_body(input int k, input bit allow_zero);
      bx[k] = {$urandom, $urandom};
      by[k] = {$urandom, $urandom};
      bz[k] = {$urandom, $urandom};
      bm[k] = (allow_zero && $urandom_range(0, 3) == 0) ? {1'($urandom_range(0, 1)), 63'd0}
                                                       : {2'b01, 30'($urandom), 32'($urandom)};
   endtask

   task automatic load(input int k);
      load_we = 1'b1;
      load_idx = 4'(k);
      load_x = bx[k];
      load_y = by[k];
      load_z = bz[k];
      load_m = bm[k];
      @(posedge clk); #1;
      load_we = 1'b0;
   endtask

   // Called mid-cycle with the DUT idle; start is sampled at the next edge (edge 0).
   task automatic run_pass(input int n, input int restart, input bit co_load, input int exp_p, input int exp_done);
      int idx, cyc, got, busy_bad, done_cyc, np;
      logic [383:0] p_snap;
      pr_t e;
      idx = (n > 1) ? $urandom_range(0, (n > MB ? MB : n) - 1) : 0;
      if (co_load) begin
         rand_body(idx, 1'b0);
         load_we = 1'b1;
         load_idx = 4'(idx);
         load_x = bx[idx];
         load_y = by[idx];
         load_z = bz[idx];
         load_m = bm[idx];
      end
      build(n);
      np = exp_q.size();
      p_snap = pvec();
      n_bodies = 5'(n);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      load_we = 1'b0;
      cyc = 1;
      got = 0;
      busy_bad = 0;
      done_cyc = -1;
      while (cyc <= 1000 && done_cyc < 0) begin
         if (cyc == restart) begin
            start = 1'b1;
            n_bodies = 5'd2;
         end else start = 1'b0;
         if (cyc <= np) begin
            e = exp_q[cyc-1];
            chk("pair", pvec(), {bx[e.i], by[e.i], bz[e.i], bx[e.j], by[e.j], bm[e.j]});
         end
         if (res_valid) begin
            if (got < np) begin
               e = exp_q[got];
               chk("result", {64'(cyc), 64'(res_idx), 62'd0, res_first, res_last, res_ax, res_ay},
                   {64'(LAT + 2 + got), 64'(e.i), 62'd0, e.first, e.last, bx[e.j], bm[e.j]});
            end else chk("extra_result", 384'(got), 384'(np));
            got++;
         end
         if (done) begin
            done_cyc = cyc;
            if (busy) busy_bad++;
         end else if (!busy && np > 0) busy_bad++;
         if (done_cyc < 0) begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      start = 1'b0;
      chk("done_cycle", 384'(done_cyc), 384'(np == 0 ? 1 : np + LAT + 2));
      chk("result_count", 384'(got), 384'(np));
      if (exp_p >= 0) chk("count_expected", 384'(got), 384'(exp_p));
      if (exp_done >= 0) chk("done_expected", 384'(done_cyc), 384'(exp_done));
      if (np == 0) chk("p_hold", pvec(), p_snap);
      chk("busy", 384'(busy_bad), 384'(0));
      @(posedge clk); #1;
      chk("done_pulse", 384'({done, busy}), 384'(0));
   endtask

   initial begin
      int bad;
      clk = 1'b0;
      rst = 1'b0;
      load_we = 1'b0;
      load_idx = '0;
      load_x = '0;
      load_y = '0;
      load_z = '0;
      load_m = '0;
      n_bodies = '0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 384'(any_out()), 384'(0));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", 384'({busy, done, res_valid}), 384'(0));
      for (int k = 0; k < MB; k++) begin
         rand_body(k, 1'b0);
         load(k);
      end

      tbl[0] = '{n: 3, restart: -1, co_load: 0, exp_p: 6, exp_done: 130};
      tbl[1] = '{n: 1, restart: -1, co_load: 0, exp_p: 0, exp_done: 1};
      tbl[2] = '{n: 0, restart: -1, co_load: 0, exp_p: 0, exp_done: 1};
      tbl[3] = '{n: 2, restart: -1, co_load: 1, exp_p: 2, exp_done: 126};
      tbl[4] = '{n: 17, restart: 50, co_load: 0, exp_p: 240, exp_done: 364};
      tbl[5] = '{n: 16, restart: -1, co_load: 0, exp_p: 240, exp_done: 364};
      tbl[6] = '{n: 3, restart: 10, co_load: 1, exp_p: 6, exp_done: 130};
      for (int t = 0; t < 7; t++)
         run_pass(tbl[t].n, tbl[t].restart, tbl[t].co_load, tbl[t].exp_p, tbl[t].exp_done);

      bm[1] = 64'h8000_0000_0000_0000;
      load(1);
      run_pass(3, -1, 0, ZM_EXP, -1);
      bm[1] = 64'h0;
      load(1);
      run_pass(3, -1, 0, ZM_EXP, -1);
      rand_body(1, 1'b0);
      load(1);

      n_bodies = 5'd3;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (59) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      bad = 0;
      repeat (200) begin
         if (any_out()) bad++;
         @(posedge clk); #1;
      end
      chk("reset_mid_pass_quiet", 384'(bad), 384'(0));
      run_pass(3, -1, 0, 6, 130);

      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 4; k++) begin
            bad = $urandom_range(0, MB - 1);
            rand_body(bad, 1'b1);
            load(bad);
         end
         run_pass($urandom_range(0, 17), -1, 1'($urandom_range(0, 1)), -1, -1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
